// File: rtl/lzw_reverse_deframer.sv
// Receive deframer: parses GMII frames into 14-bit LZW codes and flags each frame good or bad.
// Define LZW_DEFRAME_CHK_EN to verify the trailing XOR checksum byte.
`timescale 1ns/1ps
module lzw_reverse_deframer #(
  parameter int PRE_MIN   = 5,
  parameter int MAX_CODES = 736
) (
  input  logic        I_sys_clk,
  input  logic        I_sys_rst,
  input  logic [7:0]  I_gmii_rxd,
  input  logic        I_gmii_rxdv,
  input  logic        I_gmii_rxerr,
  output logic [13:0] O_compress_data,
  output logic        O_compress_data_en,
  output logic        O_frame_sop,
  output logic        O_frame_eop,
  output logic        O_frame_err,
  output logic [15:0] O_good_cnt,
  output logic [15:0] O_bad_cnt
);

  typedef enum logic [3:0] {
    IDLE, PRE, LEN_H, LEN_L, CODE_H, CODE_L, CHK, TAIL, DROP
  } state_t;

  localparam logic [3:0]  PRE_MIN_C   = 4'(PRE_MIN);
  localparam logic [15:0] MAX_CODES_C = 16'(MAX_CODES);

  state_t      state;
  logic [3:0]  pre_cnt;
  logic [7:0]  len_hi;
  logic [5:0]  code_hi;
  logic [15:0] remaining;
  logic        err;
  logic        first_code;
  logic        armed;
  logic [15:0] good_cnt;
  logic [15:0] bad_cnt;
  logic [15:0] len_word;
  logic        err_in;
  logic        in_body;
  logic        chk_bad;

  assign len_word   = {len_hi, I_gmii_rxd};
  assign err_in     = err | I_gmii_rxerr;
  assign in_body    = (state inside {LEN_H, LEN_L, CODE_H, CODE_L, CHK});
  assign O_good_cnt = good_cnt;
  assign O_bad_cnt  = bad_cnt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

`ifdef LZW_DEFRAME_CHK_EN
  logic [7:0] chk_acc;

  // Running XOR of every byte from LEN_H through the last code byte
  always_ff @(posedge I_sys_clk) begin
    if (I_sys_rst)
      chk_acc <= '0;
    else if (state == LEN_H)
      chk_acc <= I_gmii_rxd;
    else if (state inside {LEN_L, CODE_H, CODE_L})
      chk_acc <= chk_acc ^ I_gmii_rxd;
  end

  assign chk_bad = (chk_acc != I_gmii_rxd);
`else
  assign chk_bad = 1'b0;
`endif

  always_ff @(posedge I_sys_clk) begin
    if (I_sys_rst) begin
      state              <= IDLE;
      pre_cnt            <= '0;
      len_hi             <= '0;
      code_hi            <= '0;
      remaining          <= '0;
      err                <= 1'b0;
      first_code         <= 1'b0;
      armed              <= 1'b0;
      good_cnt           <= '0;
      bad_cnt            <= '0;
      O_compress_data    <= '0;
      O_compress_data_en <= 1'b0;
      O_frame_sop        <= 1'b0;
      O_frame_eop        <= 1'b0;
      O_frame_err        <= 1'b0;
    end else begin
      O_compress_data_en <= 1'b0;
      O_frame_sop        <= 1'b0;
      O_frame_eop        <= 1'b0;
      O_frame_err        <= 1'b0;
      // A frame already in progress when reset lifted must not be picked up mid-way
      if (!I_gmii_rxdv)
        armed <= 1'b1;

      if (in_body && !I_gmii_rxdv) begin
        O_frame_eop <= 1'b1;
        O_frame_err <= 1'b1;
        bad_cnt     <= sat_inc(bad_cnt);
        state       <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (I_gmii_rxdv) begin
              if (armed && I_gmii_rxd == 8'h55) begin
                state   <= PRE;
                pre_cnt <= 4'd1;
              end else begin
                state <= DROP;
              end
            end
          end
          PRE: begin
            if (!I_gmii_rxdv) begin
              state <= IDLE;
            end else if (I_gmii_rxd == 8'h55) begin
              if (pre_cnt != 4'hF)
                pre_cnt <= pre_cnt + 4'd1;
            end else if (I_gmii_rxd == 8'hD5 && pre_cnt >= PRE_MIN_C) begin
              state      <= LEN_H;
              err        <= 1'b0;
              first_code <= 1'b1;
            end else begin
              state <= DROP;
            end
          end
          LEN_H: begin
            len_hi <= I_gmii_rxd;
            err    <= err_in;
            state  <= LEN_L;
          end
          LEN_L: begin
            if (len_word == 16'd0 || len_word > MAX_CODES_C) begin
              O_frame_eop <= 1'b1;
              O_frame_err <= 1'b1;
              bad_cnt     <= sat_inc(bad_cnt);
              state       <= DROP;
            end else begin
              remaining <= len_word;
              err       <= err_in;
              state     <= CODE_H;
            end
          end
          CODE_H: begin
            code_hi <= I_gmii_rxd[5:0];
            err     <= err_in | (I_gmii_rxd[7:6] != 2'b00);
            state   <= CODE_L;
          end
          CODE_L: begin
            O_compress_data    <= {code_hi, I_gmii_rxd};
            O_compress_data_en <= 1'b1;
            O_frame_sop        <= first_code;
            first_code         <= 1'b0;
            err                <= err_in;
            remaining          <= remaining - 16'd1;
            state              <= (remaining == 16'd1) ? CHK : CODE_H;
          end
          CHK: begin
            err   <= err_in | chk_bad;
            state <= TAIL;
          end
          TAIL: begin
            if (I_gmii_rxdv) begin
              err <= 1'b1;
            end else begin
              O_frame_eop <= 1'b1;
              O_frame_err <= err_in;
              if (err_in)
                bad_cnt <= sat_inc(bad_cnt);
              else
                good_cnt <= sat_inc(good_cnt);
              state <= IDLE;
            end
          end
          DROP: begin
            if (!I_gmii_rxdv)
              state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lzw_reverse_deframer.sv
// Self-checking bench for lzw_reverse_deframer: directed vector table, random frames vs a byte-level model.
// Expectations follow LZW_DEFRAME_CHK_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_lzw_reverse_deframer;

  localparam int PRE_MIN   = 5;
  localparam int MAX_CODES = 736;
`ifdef LZW_DEFRAME_CHK_EN
  localparam bit CHK_ERR = 1'b1;
`else
  localparam bit CHK_ERR = 1'b0;
`endif

  typedef logic [7:0]  byte_q_t[$];
  typedef bit          bit_q_t[$];
  typedef logic [13:0] code_q_t[$];

  typedef struct {
    int          n_pre;
    logic [7:0]  sfd;
    logic [15:0] len;
    int          n_send;
    bit          send_chk;
    logic [7:0]  chk_flip;
    int          hi_bad;
    int          rxerr_at;
    int          n_trail;
    int          exp_codes;
    bit          exp_eop;
    bit          exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rxd;
  logic        rxdv;
  logic        rxerr;
  logic [13:0] O_compress_data;
  logic        O_compress_data_en;
  logic        O_frame_sop;
  logic        O_frame_eop;
  logic        O_frame_err;
  logic [15:0] O_good_cnt;
  logic [15:0] O_bad_cnt;

  int          checks;
  int          errors;
  logic [15:0] exp_good;
  logic [15:0] exp_bad;

  logic [13:0] obs_data[$];
  logic        obs_sop[$];
  int          eop_cnt;
  logic        eop_err;
  int          overlap_cnt;
  int          hold_viol;
  logic [13:0] last_data;

  vec_t        vecs[15];

  lzw_reverse_deframer #(.PRE_MIN(PRE_MIN), .MAX_CODES(MAX_CODES)) dut (
    .I_sys_clk          (clk),
    .I_sys_rst          (rst),
    .I_gmii_rxd         (rxd),
    .I_gmii_rxdv        (rxdv),
    .I_gmii_rxerr       (rxerr),
    .O_compress_data    (O_compress_data),
    .O_compress_data_en (O_compress_data_en),
    .O_frame_sop        (O_frame_sop),
    .O_frame_eop        (O_frame_eop),
    .O_frame_err        (O_frame_err),
    .O_good_cnt         (O_good_cnt),
    .O_bad_cnt          (O_bad_cnt)
  );

  always #2 clk = ~clk;

  // Output monitor: records codes and eops, and flags en/eop overlap or data not holding
  initial begin
    eop_cnt = 0; eop_err = 1'b0; overlap_cnt = 0; hold_viol = 0; last_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        last_data = '0;
      end else begin
        if (O_compress_data_en) begin
          obs_data.push_back(O_compress_data);
          obs_sop.push_back(O_frame_sop);
          last_data = O_compress_data;
        end else if (O_compress_data !== last_data || O_frame_sop) begin
          hold_viol++;
        end
        if (O_frame_eop) begin
          eop_cnt++;
          eop_err = O_frame_err;
          if (O_compress_data_en) overlap_cnt++;
        end
      end
    end
  end

  function automatic logic [15:0] satInc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [13:0] codeOf(input int k);
    logic [31:0] t;
    if (k == 0) return 14'h0123;
    if (k == 1) return 14'h3FFF;
    t = 32'(k * 2749 + 77);
    return t[13:0];
  endfunction

  function automatic vec_t mk(input int n_pre, input logic [7:0] sfd, input logic [15:0] len,
                              input int n_send, input bit send_chk, input logic [7:0] chk_flip,
                              input int hi_bad, input int rxerr_at, input int n_trail,
                              input int exp_codes, input bit exp_eop, input bit exp_err);
    vec_t v;
    v.n_pre = n_pre; v.sfd = sfd; v.len = len; v.n_send = n_send; v.send_chk = send_chk;
    v.chk_flip = chk_flip; v.hi_bad = hi_bad; v.rxerr_at = rxerr_at; v.n_trail = n_trail;
    v.exp_codes = exp_codes; v.exp_eop = exp_eop; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic driveByte(input logic [7:0] d, input logic er, input logic dv);
    @(negedge clk);
    rxd = d; rxerr = er; rxdv = dv;
  endtask

  task automatic applyStimulus(input byte_q_t b, input bit_q_t e, input int gap);
    foreach (b[j]) driveByte(b[j], e[j], 1'b1);
    for (int g = 0; g < gap; g++) driveByte(8'h00, 1'b0, 1'b0);
  endtask

  task automatic clearObs();
    obs_data = {};
    obs_sop = {};
    eop_cnt = 0;
    eop_err = 1'b0;
  endtask

  task automatic buildFrame(input vec_t v, output byte_q_t b, output bit_q_t e);
    logic [7:0]  x, hi, lo;
    logic [13:0] c;
    b = {}; e = {};
    for (int i = 0; i < v.n_pre; i++) b.push_back(8'h55);
    b.push_back(v.sfd);
    b.push_back(v.len[15:8]);
    b.push_back(v.len[7:0]);
    x = v.len[15:8] ^ v.len[7:0];
    for (int k = 0; k < v.n_send; k++) begin
      c  = codeOf(k);
      hi = {2'b00, c[13:8]};
      if (k == v.hi_bad) hi = hi | 8'h40;
      lo = c[7:0];
      b.push_back(hi);
      b.push_back(lo);
      x = x ^ hi ^ lo;
    end
    if (v.send_chk) b.push_back(x ^ v.chk_flip);
    for (int t = 0; t < v.n_trail; t++) b.push_back(8'hA5);
    for (int j = 0; j < b.size(); j++) e.push_back(j == v.rxerr_at);
  endtask

  // Reference model: walks the byte list of one burst (rxdv high throughout, then low)
  task automatic modelFrame(input byte_q_t b, input bit_q_t e,
                            output code_q_t codes, output bit has_eop, output bit err);
    int         i, n, pre, len_n;
    logic [7:0] x, hi;
    bit         bad;
    codes = {}; has_eop = 1'b0; err = 1'b0;
    n = b.size();
    if (n == 0 || b[0] != 8'h55) return;
    pre = 1; i = 1;
    while (i < n && b[i] == 8'h55) begin pre++; i++; end
    if (i >= n || b[i] != 8'hD5 || ((pre > 15) ? 15 : pre) < PRE_MIN) return;
    i++;
    has_eop = 1'b1;
    err = 1'b1;
    if (i + 1 >= n) return;
    len_n = {b[i], b[i+1]};
    bad = e[i] | e[i+1];
    x = b[i] ^ b[i+1];
    i += 2;
    if (len_n == 0 || len_n > MAX_CODES) return;
    for (int k = 0; k < len_n; k++) begin
      if (i + 1 >= n) return;
      hi = b[i];
      bad = bad | e[i] | e[i+1] | (hi[7:6] != 2'b00);
      x = x ^ hi ^ b[i+1];
      codes.push_back({hi[5:0], b[i+1]});
      i += 2;
    end
    if (i >= n) return;
    bad = bad | e[i];
`ifdef LZW_DEFRAME_CHK_EN
    if (x != b[i]) bad = 1'b1;
`endif
    i++;
    if (i < n) bad = 1'b1;
    err = bad;
  endtask

  task automatic verifyFrame(input code_q_t exp, input bit exp_eop, input bit exp_err, input int tag);
    int mism, sopm;
    if (exp_eop) begin
      if (exp_err) exp_bad = satInc(exp_bad);
      else         exp_good = satInc(exp_good);
    end
    mism = 0; sopm = 0;
    for (int k = 0; k < obs_data.size() && k < exp.size(); k++)
      if (obs_data[k] !== exp[k]) mism++;
    for (int k = 0; k < obs_sop.size(); k++)
      if (obs_sop[k] !== (k == 0)) sopm++;
    checkOutput($sformatf("f%0d code count", tag), obs_data.size(), exp.size());
    checkOutput($sformatf("f%0d code values", tag), mism, 0);
    checkOutput($sformatf("f%0d sop", tag), sopm, 0);
    checkOutput($sformatf("f%0d eop count", tag), eop_cnt, exp_eop ? 1 : 0);
    if (exp_eop) checkOutput($sformatf("f%0d eop err", tag), eop_err, exp_err);
    checkOutput($sformatf("f%0d good_cnt", tag), O_good_cnt, exp_good);
    checkOutput($sformatf("f%0d bad_cnt", tag), O_bad_cnt, exp_bad);
  endtask

  initial begin
    byte_q_t     b;
    bit_q_t      e;
    code_q_t     expc;
    bit          ee, er;
    int          n_pre, len_n, n_send, cut;
    logic [7:0]  x, hi;
    logic [13:0] c;

    checks = 0; errors = 0;
    rst = 1'b1; rxd = '0; rxdv = 1'b0; rxerr = 1'b0;
    exp_good = '0; exp_bad = '0;

    repeat (4) @(negedge clk);
    checkOutput("reset data", O_compress_data, 0);
    checkOutput("reset en", O_compress_data_en, 0);
    checkOutput("reset sop", O_frame_sop, 0);
    checkOutput("reset eop", O_frame_eop, 0);
    checkOutput("reset err", O_frame_err, 0);
    checkOutput("reset good_cnt", O_good_cnt, 0);
    checkOutput("reset bad_cnt", O_bad_cnt, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Directed vectors: frame construction fields, then expected code count / eop / err
    vecs[0]  = mk(7, 8'hD5, 16'd2,   2,   1, 8'h00, -1, -1, 0, 2,   1, 0);
    vecs[1]  = mk(7, 8'hD5, 16'd2,   2,   1, 8'h01, -1, -1, 0, 2,   1, CHK_ERR);
    vecs[2]  = mk(7, 8'hD5, 16'd0,   2,   1, 8'h00, -1, -1, 0, 0,   1, 1);
    vecs[3]  = mk(7, 8'hD5, 16'd737, 2,   1, 8'h00, -1, -1, 0, 0,   1, 1);
    vecs[4]  = mk(7, 8'hD5, 16'd3,   2,   0, 8'h00, -1, -1, 0, 2,   1, 1);
    vecs[5]  = mk(7, 8'hD5, 16'd2,   2,   1, 8'h00, -1, 11, 0, 2,   1, 1);
    vecs[6]  = mk(4, 8'hD5, 16'd2,   2,   1, 8'h00, -1, -1, 0, 0,   0, 0);
    vecs[7]  = mk(1, 8'h12, 16'd2,   2,   1, 8'h00, -1, -1, 0, 0,   0, 0);
    vecs[8]  = mk(7, 8'hD5, 16'd2,   2,   1, 8'h00,  1, -1, 0, 2,   1, 1);
    vecs[9]  = mk(7, 8'hD5, 16'd2,   2,   1, 8'h00, -1, -1, 1, 2,   1, 1);
    vecs[10] = mk(5, 8'hD5, 16'd2,   2,   1, 8'h00, -1, -1, 0, 2,   1, 0);
    vecs[11] = mk(0, 8'hD5, 16'd2,   2,   1, 8'h00, -1, -1, 0, 0,   0, 0);
    vecs[12] = mk(7, 8'hD5, 16'd736, 736, 1, 8'h00, -1, -1, 0, 736, 1, 0);
    vecs[13] = mk(6, 8'hD5, 16'd1,   1,   1, 8'h00, -1, -1, 0, 1,   1, 0);
    vecs[14] = mk(7, 8'hD5, 16'd2,   2,   1, 8'h00, -1,  8, 0, 2,   1, 1);

    for (int v = 0; v < 15; v++) begin
      buildFrame(vecs[v], b, e);
      expc = {};
      for (int k = 0; k < vecs[v].exp_codes; k++) expc.push_back(codeOf(k));
      clearObs();
      applyStimulus(b, e, 6);
      verifyFrame(expc, vecs[v].exp_eop, vecs[v].exp_err, v);
    end

    // Random bursts checked against the byte-level model
    for (int r = 0; r < 40; r++) begin
      n_pre = $urandom_range(3, 9);
      len_n = $urandom_range(1, 6);
      case ($urandom_range(0, 19))
        0: len_n = 0;
        1: len_n = 737 + $urandom_range(0, 100);
        default: ;
      endcase
      b = {}; e = {};
      for (int i = 0; i < n_pre; i++) b.push_back(8'h55);
      b.push_back(($urandom_range(0, 9) == 0) ? 8'hD4 : 8'hD5);
      b.push_back(len_n[15:8]);
      b.push_back(len_n[7:0]);
      x = len_n[15:8] ^ len_n[7:0];
      n_send = (len_n > 6) ? 3 : len_n;
      for (int k = 0; k < n_send; k++) begin
        c  = 14'($urandom);
        hi = {2'b00, c[13:8]} | (($urandom_range(0, 11) == 0) ? 8'h80 : 8'h00);
        b.push_back(hi);
        b.push_back(c[7:0]);
        x = x ^ hi ^ c[7:0];
      end
      b.push_back(x ^ (($urandom_range(0, 6) == 0) ? 8'h01 : 8'h00));
      if ($urandom_range(0, 9) == 0) b.push_back(8'h5A);
      if ($urandom_range(0, 7) == 0) begin
        cut = $urandom_range(1, b.size() - 1);
        while (b.size() > cut) void'(b.pop_back());
      end
      for (int j = 0; j < b.size(); j++) e.push_back($urandom_range(0, 39) == 0);
      modelFrame(b, e, expc, ee, er);
      clearObs();
      applyStimulus(b, e, 5);
      verifyFrame(expc, ee, er, 100 + r);
    end

    // Code latency: valid one clock after the low byte is on the bus
    buildFrame(vecs[0], b, e);
    clearObs();
    for (int j = 0; j <= 10; j++) driveByte(b[j], 1'b0, 1'b1);
    @(posedge clk); #1;
    checkOutput("latency en after hi byte", O_compress_data_en, 0);
    driveByte(b[11], 1'b0, 1'b1);
    @(posedge clk); #1;
    checkOutput("latency en after lo byte", O_compress_data_en, 1);
    checkOutput("latency data", O_compress_data, 14'h0123);
    checkOutput("latency sop", O_frame_sop, 1);
    for (int j = 12; j < b.size(); j++) driveByte(b[j], 1'b0, 1'b1);
    for (int g = 0; g < 6; g++) driveByte(8'h00, 1'b0, 1'b0);
    expc = {14'h0123, 14'h3FFF};
    verifyFrame(expc, 1'b1, 1'b0, 200);

    // Reset in the middle of a frame, then a frame arriving before rxdv has dropped
    for (int j = 0; j <= 11; j++) driveByte(b[j], 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1; rxd = 8'h55; rxdv = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_good = '0; exp_bad = '0;
    clearObs();
    for (int j = 0; j < b.size(); j++) driveByte(b[j], 1'b0, 1'b1);
    for (int g = 0; g < 6; g++) driveByte(8'h00, 1'b0, 1'b0);
    expc = {};
    verifyFrame(expc, 1'b0, 1'b0, 300);
    clearObs();
    applyStimulus(b, e, 6);
    expc = {14'h0123, 14'h3FFF};
    verifyFrame(expc, 1'b1, 1'b0, 301);

    // Bad-frame counter held at its ceiling must not wrap
    @(negedge clk);
    force dut.bad_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.bad_cnt;
    @(negedge clk);
    exp_bad = 16'hFFFF;
    checkOutput("bad_cnt at ceiling", O_bad_cnt, 16'hFFFF);
    buildFrame(vecs[2], b, e);
    clearObs();
    applyStimulus(b, e, 6);
    expc = {};
    verifyFrame(expc, 1'b1, 1'b1, 400);

    checkOutput("en/eop overlap", overlap_cnt, 0);
    checkOutput("data hold when idle", hold_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lzw_reverse_deframer.md
Name: lzw_reverse_deframer

Overview:
Receive-side counterpart of the LZW forward framer. Parses GMII receive frames carrying LZW dictionary codes and strips preamble, SFD, length and checksum. Emits 14-bit compressed codes cut-through to the downstream LZW decompressor. Flags each frame good or bad at end of frame and keeps saturating status counters.

Parameters:
PRE_MIN, 5, minimum count of 0x55 preamble bytes required before SFD 0xD5
MAX_CODES, 736, maximum legal code count per frame; length field above this is an error

Ports:
I_sys_clk  input  1  system clock, 250 MHz
I_sys_rst  input  1  synchronous reset, active-high
I_gmii_rxd  input  8  GMII receive data
I_gmii_rxdv  input  1  GMII receive data valid
I_gmii_rxerr  input  1  GMII receive error
O_compress_data  output  14  recovered dictionary code
O_compress_data_en  output  1  code valid, one-cycle pulse per code
O_frame_sop  output  1  pulse coincident with the first code of a frame
O_frame_eop  output  1  pulse at frame end; not coincident with any code
O_frame_err  output  1  valid only with O_frame_eop; 1 = frame bad
O_good_cnt  output  16  good-frame counter, saturates at 0xFFFF
O_bad_cnt  output  16  bad-frame counter, saturates at 0xFFFF

Behaviour:
- Clock and reset: single clock I_sys_clk. Reset I_sys_rst is synchronous and active-high.
- Reset values: all outputs 0; FSM in IDLE; counters 0. Reset mid-frame aborts the frame with no eop. After reset, the receiver waits for rxdv low before it accepts a new frame.
- Frame format after SFD, all bytes big-endian:
  - LEN_H, LEN_L: code count N.
  - N code pairs: {2'b00, code[13:8]}, then code[7:0].
  - CHK: XOR of every byte from LEN_H through the last code byte.
- FSM states: IDLE, PRE, LEN_H, LEN_L, CODE_H, CODE_L, CHK, TAIL, DROP.
- IDLE:
  - rxdv=1 and rxd=0x55 -> PRE, pre_cnt=1.
  - rxdv=1 with any other byte -> DROP, no counters touched.
- PRE:
  - rxd=0x55: pre_cnt++, saturating at 15.
  - rxd=0xD5 and pre_cnt>=PRE_MIN -> LEN_H.
  - Any other byte, or SFD with short preamble -> DROP, no counters.
  - rxdv=0 -> IDLE.
- LEN_L:
  - If N==0 or N>MAX_CODES -> DROP, bad_cnt++, eop+err pulse.
  - Otherwise -> CODE_H.
- CODE_H:
  - Latch the high byte.
  - rxd[7:6]!=0 sets the sticky err flag; the code is still emitted using bits [5:0].
- CODE_L:
  - The next cycle drives O_compress_data={hi[5:0],rxd} with en=1.
  - Latency: 1 clock after the low-byte sample.
  - sop=1 on the first code. Decrement the remaining count; at 0 -> CHK, else -> CODE_H.
- CHK: compare the running XOR against rxd (see feature) -> TAIL.
- TAIL:
  - Expects rxdv=0. Any further rxdv=1 byte sets err and stays in TAIL.
  - When rxdv falls: eop=1 with err, then good_cnt or bad_cnt ++, then -> IDLE.
- Early rxdv=0 in LEN_H..CHK: eop with err=1, bad_cnt++, -> IDLE. Codes already emitted are not retracted.
- rxerr=1 in any state from LEN_H through TAIL sets the sticky err.
- DROP: waits for rxdv=0 -> IDLE.
- O_compress_data holds its last value when en=0.
- At most one of en and eop is asserted per cycle.

Optional Feature:
LZW_DEFRAME_CHK_EN
- Defined: CHK byte compared against the running XOR; a mismatch sets err.
- Undefined: XOR logic not built; CHK byte consumed and ignored; frame validity depends only on length, rxerr, code high bits, truncation and trailing bytes.

Test Plan:
- Good frame: 7x55, D5, 00 02, 01 23, 3F FF, chk=0x00^0x02^0x01^0x23^0x3F^0xFF. Expect codes 0x0123 (sop=1) then 0x3FFF, eop err=0, good_cnt=1.
- Bad checksum, feature on: same frame with chk^0x01. Expect both codes, eop err=1, bad_cnt=1. With feature off: err=0, good_cnt=1.
- Length errors: LEN=0x0000, then LEN=737. Each gives eop err=1 right after LEN_L, no codes, bad_cnt +1 each, remaining bytes dropped.
- Truncation and rxerr:
  - N=3, rxdv falls after 2 codes: 2 codes emitted, eop err=1.
  - rxerr pulsed on a code byte: err=1 at eop.
- Preamble and SFD:
  - 4x55 then D5: dropped, no outputs, counters unchanged.
  - 0x55 then 0x12: dropped.
- Reset mid-frame, then a frame starting while rxdv stays high: no eop. The next full good frame after an rxdv-low gap decodes correctly. Also check saturation: a forced bad_cnt of 0xFFFF stays at 0xFFFF.
